// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: combinational hit path, byte-serial line fill
// from the shared memory arbiter on a miss.
module icache_fetch #(
    parameter int INDEX_BIT     = 6,
    parameter int LINE_WORD_BIT = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] pc_in,
    input  logic        inst_req,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_a,
    input  logic [7:0]  mem_din
);

    localparam int OFF_BIT    = LINE_WORD_BIT + 2;
    localparam int LINE_BYTES = 1 << OFF_BIT;
    localparam int LINES      = 1 << INDEX_BIT;
    localparam int TAG_BIT    = 32 - INDEX_BIT - OFF_BIT;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int CNT_W      = LINE_WORD_BIT + 3;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, FILL} state_t;
    state_t state, state_nx;

    logic [LINES-1:0]     valid;
    logic [TAG_BIT-1:0]   tag_arr  [LINES];
    logic [LINE_W-1:0]    data_arr [LINES];
    logic [LINE_W-1:0]    line_buf, line_nx;
    logic [31:0]          base;
    logic [CNT_W-1:0]     issue_cnt, recv_cnt;

    logic [INDEX_BIT-1:0]     pc_idx, fill_idx;
    logic [TAG_BIT-1:0]       pc_tag, fill_tag;
    logic [LINE_WORD_BIT-1:0] pc_word;
    logic                     hit, capture, fill_done;
    logic                     unused_pc_lsb;

    assign pc_idx        = pc_in[OFF_BIT +: INDEX_BIT];
    assign pc_tag        = pc_in[31 -: TAG_BIT];
    assign pc_word       = pc_in[2 +: LINE_WORD_BIT];
    assign fill_idx      = base[OFF_BIT +: INDEX_BIT];
    assign fill_tag      = base[31 -: TAG_BIT];
    assign unused_pc_lsb = ^pc_in[1:0];

    assign hit        = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign inst_ready = rdy_in && inst_req && hit && (state == IDLE);
    assign inst       = inst_ready ? data_arr[pc_idx][{pc_word, 5'b00000} +: 32] : '0;

    // The first FILL cycle only issues; each later cycle receives the byte addressed one cycle earlier.
    assign capture   = (state == FILL) && (issue_cnt != CNT_ONE);
    assign fill_done = capture && (recv_cnt == CNT_LAST);

    always_comb begin
        line_nx = line_buf;
        line_nx[{recv_cnt[OFF_BIT-1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        unique case (state)
            IDLE: begin
                if (inst_req && !hit) state_nx = WAIT_GNT;
            end
            WAIT_GNT: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nx = FILL;
            end
            FILL: begin
                mem_req = 1'b1;
                if (fill_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   state <= IDLE;
        else if (rdy_in) state <= state_nx;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid     <= '0;
            mem_a     <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (rdy_in) begin
            if (state == WAIT_GNT && mem_gnt) begin
                mem_a     <= base;
                issue_cnt <= CNT_ONE;
                recv_cnt  <= '0;
            end
            if (state == FILL && issue_cnt < CNT_FULL) begin
                mem_a     <= base + 32'(issue_cnt);
                issue_cnt <= issue_cnt + CNT_ONE;
            end
            if (capture)   recv_cnt <= recv_cnt + CNT_ONE;
            if (fill_done) valid[fill_idx] <= 1'b1;
        end
    end

    // Line storage carries no reset; the valid bits alone decide what may hit.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (state == IDLE && inst_req && !hit) base <= {pc_in[31:OFF_BIT], {OFF_BIT{1'b0}}};
            if (capture) line_buf <= line_nx;
            if (fill_done) begin
                data_arr[fill_idx] <= line_nx;
                tag_arr[fill_idx]  <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: byte memory responder plus a line-level cache model
// that predicts hits, fill address sequences and returned words.
module tb_icache_fetch;

    logic        clk_in, rst_n_in, rdy_in, inst_req, mem_gnt;
    logic [31:0] pc_in;
    logic        inst_ready, mem_req;
    logic [31:0] inst, mem_a;
    logic [7:0]  mem_din;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [4096];
    bit          mvalid [64];
    int unsigned mtag [64];
    logic [31:0] model_last_a;

    icache_fetch dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rdy_in    (rdy_in),
        .pc_in     (pc_in),
        .inst_req  (inst_req),
        .inst_ready(inst_ready),
        .inst      (inst),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_a     (mem_a),
        .mem_din   (mem_din)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory: the byte addressed in cycle k appears in cycle k+1; paused with rdy_in.
    always @(posedge clk_in) if (rdy_in) mem_din <= mem[mem_a[11:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        int unsigned idx;
        idx = (pc / 16) % 64;
        return mvalid[idx] && (mtag[idx] == pc / 1024);
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] pc);
        int unsigned a;
        a = pc % 4096;
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        model_last_a = 32'h0;
    endfunction

    // Called at the negedge of the miss cycle; returns at the negedge of the first IDLE cycle.
    task automatic miss_path(input logic [31:0] base, input int gnt_wait, input int pause_j,
                             input logic [31:0] sw_pc, input int sw_j, input string tag);
        logic [31:0] exp_a;
        bit          exp;
        for (int k = 0; k <= gnt_wait; k++) begin
            @(negedge clk_in);
            chk({tag, " wait mem_req"}, {31'b0, mem_req}, 32'd1);
            chk({tag, " wait inst_ready"}, {31'b0, inst_ready}, 32'd0);
            chk({tag, " wait mem_a"}, mem_a, model_last_a);
            if (k == gnt_wait) mem_gnt = 1'b1;
        end
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk_in);
            exp_a = base + ((j < 15) ? j : 15);
            chk({tag, " fill mem_a"}, mem_a, exp_a);
            chk({tag, " fill mem_req"}, {31'b0, mem_req}, 32'd1);
            chk({tag, " fill inst_ready"}, {31'b0, inst_ready}, 32'd0);
            if (j == sw_j) pc_in = sw_pc;
            if (j == pause_j) begin
                rdy_in = 1'b0;
                repeat (3) begin
                    @(negedge clk_in);
                    chk({tag, " pause mem_a"}, mem_a, exp_a);
                    chk({tag, " pause inst_ready"}, {31'b0, inst_ready}, 32'd0);
                    chk({tag, " pause mem_req"}, {31'b0, mem_req}, 32'd1);
                end
                rdy_in = 1'b1;
            end
        end
        @(negedge clk_in);
        mvalid[(base / 16) % 64] = 1'b1;
        mtag[(base / 16) % 64]   = base / 1024;
        model_last_a             = base + 15;
        exp = inst_req && model_hit(pc_in);
        chk({tag, " done mem_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, " done inst_ready"}, {31'b0, inst_ready}, {31'b0, exp});
        chk({tag, " done inst"}, inst, exp ? memword(pc_in) : 32'h0);
    endtask

    task automatic eval(input string tag, input int gnt_wait, input int pause_j,
                        input logic [31:0] sw_pc, input int sw_j);
        bit exp;
        exp = inst_req && model_hit(pc_in);
        chk({tag, " inst_ready"}, {31'b0, inst_ready}, {31'b0, exp});
        chk({tag, " inst"}, inst, exp ? memword(pc_in) : 32'h0);
        chk({tag, " idle mem_req"}, {31'b0, mem_req}, 32'd0);
        if (inst_req && !model_hit(pc_in)) begin
            if (gnt_wait > 0) mem_gnt = 1'b0;
            miss_path(pc_in & 32'hFFFF_FFF0, gnt_wait, pause_j, sw_pc, sw_j, tag);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input bit req, input string tag,
                         input int gnt_wait = 0, input int pause_j = -1,
                         input logic [31:0] sw_pc = 32'h0, input int sw_j = -1);
        pc_in    = pc;
        inst_req = req;
        @(negedge clk_in);
        eval(tag, gnt_wait, pause_j, sw_pc, sw_j);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        model_clear();
        rst_n_in = 1'b0; rdy_in = 1'b1; inst_req = 1'b1; mem_gnt = 1'b1;
        pc_in = 32'h0; mem_din = 8'h0;

        @(negedge clk_in);
        chk("reset inst_ready", {31'b0, inst_ready}, 32'd0);
        chk("reset inst", inst, 32'h0);
        chk("reset mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset mem_a", mem_a, 32'h0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;

        // Cold miss, then same-line hits.
        fetch(32'h0, 1'b1, "cold");
        @(negedge clk_in);
        chk("cold word0", inst, 32'h0010_0513);
        @(posedge clk_in); #1;
        fetch(32'h4, 1'b1, "hit4");
        fetch(32'h8, 1'b1, "hit8");
        fetch(32'hC, 1'b1, "hitC");

        // Conflict eviction, then refill of 0x0 with pc moving to 0x100 mid-fill.
        fetch(32'h400, 1'b1, "evict");
        fetch(32'h0, 1'b1, "refill0", 0, -1, 32'h100, 4);
        miss_path(32'h100, 0, -1, 32'h0, -1, "fill100");
        @(posedge clk_in); #1;
        fetch(32'h0, 1'b1, "after0");
        fetch(32'h104, 1'b1, "after104");

        // rdy_in low for three cycles mid-fill.
        fetch(32'h800, 1'b1, "rdy", 0, 6);
        fetch(32'h804, 1'b1, "rdy804");
        fetch(32'h808, 1'b1, "rdy808");
        fetch(32'h80C, 1'b1, "rdy80C");
        fetch(32'h804, 1'b0, "noreq");

        // Reset during the fill, just before byte 7 is captured.
        pc_in = 32'h0; inst_req = 1'b1;
        @(negedge clk_in);
        chk("rstfill miss", {31'b0, inst_ready}, 32'd0);
        repeat (10) @(negedge clk_in);
        chk("rstfill mem_a", mem_a, 32'h8);
        rst_n_in = 1'b0;
        #1;
        model_clear();
        chk("rstfill mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstfill mem_a0", mem_a, 32'h0);
        chk("rstfill inst_ready", {31'b0, inst_ready}, 32'd0);
        pc_in = 32'h800;
        #1;
        chk("rstfill old line", {31'b0, inst_ready}, 32'd0);
        chk("rstfill inst", inst, 32'h0);
        @(negedge clk_in);
        chk("rstfill hold", {31'b0, inst_ready}, 32'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;

        // Re-fetch after reset with a delayed grant.
        fetch(32'h0, 1'b1, "gntdly", 5);
        fetch(32'h800, 1'b1, "post800");

        for (int n = 0; n < 30; n++) begin
            logic [31:0] rpc;
            bit          rq;
            int          gw, pj;
            rpc = 32'($urandom_range(0, 1023)) * 4;
            rq  = ($urandom_range(0, 4) != 0);
            gw  = int'($urandom_range(0, 3));
            pj  = int'($urandom_range(0, 30));
            fetch(rpc, rq, "rand", gw, pj);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the instruction-fetch/issue unit and the shared byte-wide memory arbiter.
- Returns the 32-bit instruction at `pc_in` combinationally on a hit, in the same cycle as the request.
- On a miss, requests the bus, reads the whole line byte-serially, installs it, and serves the fetch from the following cycle on.

Parameters:
- INDEX_BIT, 6, log2 of line count (64 lines).
- LINE_WORD_BIT, 2, log2 of words per line (4 words = 16 bytes). Tag is `pc[31:INDEX_BIT+LINE_WORD_BIT+2]`.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous active-low
- rdy_in  input  1  global ready; low pauses the block
- pc_in  input  32  fetch address (word aligned)
- inst_req  input  1  fetch request for pc_in
- inst_ready  output  1  pc_in hit; inst valid this cycle
- inst  output  32  instruction word, little-endian
- mem_req  output  1  bus request to arbiter
- mem_gnt  input  1  arbiter grant
- mem_a  output  32  byte read address
- mem_din  input  8  read byte

Behaviour:
- Reset (async, rst_n_in low):
  - All valid bits cleared; state IDLE.
  - mem_req=0, mem_a=0, byte counters=0.
  - inst_ready=0 and inst=0 while in reset.
- Hit path (combinational):
  - `hit = valid[idx] && tag[idx]==pc_tag`.
  - `inst_ready = rdy_in && inst_req && hit && state==IDLE`.
  - When inst_ready=1, inst = selected word; otherwise inst=0.
- Memory contract: the byte at the address driven on mem_a during cycle k is valid on mem_din during cycle k+1.
- FSM states:
  - IDLE: if rdy_in && inst_req && !hit, latch line base (pc_in with low LINE_WORD_BIT+2 bits zeroed) plus index and tag, then go to WAIT_GNT.
  - WAIT_GNT: mem_req=1. When mem_gnt=1 at the edge, set mem_a<=base, issue_cnt<=1, recv_cnt<=0, and go to FILL.
  - FILL: mem_req=1.
    - Each edge: if issue_cnt<LINE_BYTES, set mem_a<=base+issue_cnt and issue_cnt++.
    - From the second FILL cycle on, capture mem_din into line-buffer byte recv_cnt and increment recv_cnt.
    - On the edge capturing byte LINE_BYTES-1: write the buffer to data[idx], write tag[idx], set valid[idx]=1, mem_req<=0, go to IDLE.
    - FILL lasts LINE_BYTES+1 cycles.
- Latency: miss seen in cycle M with grant already high gives WAIT_GNT in M+1, FILL in M+2..M+18, and a hit in M+19 (16-byte line).
- No inst_ready outside IDLE, even if pc_in would hit another valid line. This keeps the IU from advancing during a fill.
- Replacement: always overwrite the indexed line; no dirty state (read-only).
- pc_in / inst_req changing during WAIT_GNT or FILL:
  - The fill is not aborted; it completes, and that line is installed.
  - Re-evaluation happens in IDLE; a new miss then starts a new fill.
  - This covers IU flush on mispredict (clear) and JALR stall.
- mem_gnt dropping mid-FILL is an arbiter protocol error; the block ignores it. The arbiter holds the grant until mem_req falls.
- rdy_in low:
  - State, counters, mem_a and mem_req are held; inst_ready is forced 0.
  - The memory side is paused by the system in the same cycles, so no byte is lost.
- Reset asserted mid-fill: immediate abort; the partial line is not installed, valid stays 0, and mem_req falls asynchronously.
- Widths: mem_a is 32-bit wrapping add of base + issue_cnt; issue_cnt and recv_cnt are LINE_WORD_BIT+3 bits.

Test Plan:
- Cold miss:
  - Setup: bytes 0x0..0x3 = 13 05 10 00, mem_gnt tied 1, pc_in=0, inst_req=1.
  - Required: inst_ready=0 for 18 cycles; mem_a steps 0x0..0xF, one per cycle.
  - Then inst_ready=1 with inst=0x00100513; pc_in=0x4..0xC hit immediately, no new mem_req.
- Conflict eviction:
  - Stimulus: after line 0x0 is filled, fetch pc_in=0x400 (same index 0, tag differs).
  - Required: a full refill occurs, then pc_in=0x0 misses again.
- Grant delay: mem_gnt held low 5 cycles after mem_req rises -> mem_a stays 0 and no bytes are captured; the fill starts the cycle after mem_gnt=1.
- pc change mid-fill: pc_in switches from 0x0 to 0x100 during FILL -> line 0x0 is still installed; a second fill for 0x100 follows in IDLE.
- rdy_in low 3 cycles mid-FILL (memory also paused) -> mem_a frozen and the final line bytes are unchanged versus the uninterrupted run.
- Reset mid-FILL at byte 7:
  - Required: mem_req drops at once; after release, pc_in=0x0 misses again.
  - No partial line is ever hit; inst_ready=0 throughout reset.
